// File: rtl/ula_arbiter.sv
// ----------------------------------------------------------------------------
// ula_arbiter
// Lets two requesters share one combinational ULA. At most one operation is
// in flight: the arbiter accepts a request, drives the ULA from its latched
// copy for one cycle (MUL_CYCLES cycles for multiply), captures the result,
// and keeps the response up until the owning requester consumes it.
// When both requesters are valid at once, the round-robin pointer picks one.
//
// Ports
//   clk, reset                      clock, synchronous active-high reset
//   req0_*/req1_*                   valid/ready request channels (a, b, op)
//   rsp0_*/rsp1_*                   valid/ready response channels
//                                   (result, zero, err)
//   ula_in1, ula_in2, ula_control   operands and control code to the ULA
//   ula_result, zero_flag           combinational results from the ULA
// ----------------------------------------------------------------------------
module ula_arbiter #(
    parameter int MUL_CYCLES = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [3:0]  req0_op,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [3:0]  req1_op,
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic [31:0] rsp0_result,
    output logic        rsp0_zero,
    output logic        rsp0_err,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [31:0] rsp1_result,
    output logic        rsp1_zero,
    output logic        rsp1_err,
    output logic [31:0] ula_in1,
    output logic [31:0] ula_in2,
    output logic [3:0]  ula_control,
    input  logic [31:0] ula_result,
    input  logic        zero_flag
);

    localparam logic [3:0] OP_MUL     = 4'b0110;
    localparam logic [3:0] OP_MAX     = 4'b1000;
    localparam logic [3:0] MUL_COUNT  = 4'(MUL_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t      r_state;
    state_t      w_nextState;

    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [3:0]  r_op;
    logic        r_owner;
    logic [3:0]  r_count;
    logic        r_rr;
    logic [31:0] r_result;
    logic        r_zero;
    logic        r_err;

    logic        w_grant;
    logic        w_accept;
    logic        w_opValid;
    logic        w_consume;
    logic        w_lastExec;

    // With both requesters valid the round-robin pointer decides; otherwise
    // whichever one is valid wins (req1 only when req1 is the sole valid).
    assign w_grant    = (req0_valid && req1_valid) ? r_rr : req1_valid;
    assign req0_ready = (r_state == IDLE) && req0_valid && !w_grant;
    assign req1_ready = (r_state == IDLE) && req1_valid && w_grant;
    assign w_accept   = req0_ready || req1_ready;

    assign w_opValid  = (r_op <= OP_MAX);
    assign w_lastExec = (r_state == EXEC) && (r_count == 4'd1);
    assign w_consume  = (r_state == RESP) &&
                        (r_owner ? rsp1_ready : rsp0_ready);

    // State register; reset also throws away any half-finished transaction.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic. EXEC leaves on the edge where the counter is 1, so a
    // load of 1 gives one EXEC cycle and a load of MUL_CYCLES gives that many.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_accept)   w_nextState = EXEC;
            EXEC:    if (w_lastExec) w_nextState = RESP;
            RESP:    if (w_consume)  w_nextState = IDLE;
            default:                 w_nextState = IDLE;
        endcase
    end

    // Datapath: latch the granted request, count down the EXEC cycles,
    // capture the ULA output on the last one, and flip the round-robin
    // pointer away from the owner once its response is consumed.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= '0;
            r_owner  <= 1'b0;
            r_count  <= '0;
            r_rr     <= 1'b0;
            r_result <= '0;
            r_zero   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_owner <= req1_ready;
                r_a     <= req1_ready ? req1_a  : req0_a;
                r_b     <= req1_ready ? req1_b  : req0_b;
                r_op    <= req1_ready ? req1_op : req0_op;
                r_count <= ((req1_ready ? req1_op : req0_op) == OP_MUL) ?
                           MUL_COUNT : 4'd1;
            end
            if (r_state == EXEC) begin
                r_count <= r_count - 4'd1;
            end
            if (w_lastExec) begin
                // An invalid code never reaches the ULA, so the flags are
                // forced here instead of trusting whatever it returns for 0/0.
                r_result <= w_opValid ? ula_result : '0;
                r_zero   <= w_opValid ? zero_flag  : 1'b0;
                r_err    <= !w_opValid;
            end
            if (w_consume) begin
                r_rr <= !r_owner;
            end
        end
    end

    // Output decode: the ULA only sees operands during EXEC of a valid op,
    // and response fields are gated so a non-owner always reads zero.
    always_comb begin
        ula_in1     = '0;
        ula_in2     = '0;
        ula_control = '0;
        if ((r_state == EXEC) && w_opValid) begin
            ula_in1     = r_a;
            ula_in2     = r_b;
            ula_control = r_op;
        end
        rsp0_valid  = (r_state == RESP) && !r_owner;
        rsp1_valid  = (r_state == RESP) && r_owner;
        rsp0_result = rsp0_valid ? r_result : '0;
        rsp0_zero   = rsp0_valid && r_zero;
        rsp0_err    = rsp0_valid && r_err;
        rsp1_result = rsp1_valid ? r_result : '0;
        rsp1_zero   = rsp1_valid && r_zero;
        rsp1_err    = rsp1_valid && r_err;
    end

endmodule

// File: tb/tb_ula_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ula_arbiter
// Self-checking bench for ula_arbiter. A behavioural ULA closes the loop on
// the ula_* ports. A vector table drives single transactions; hand-written
// sequences cover simultaneous requests, a stalled response and a reset that
// lands in the middle of a multiply.
// ----------------------------------------------------------------------------
module tb_ula_arbiter;

    localparam int MUL = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  req0_op, req1_op;
    logic        rsp0_valid, rsp0_ready, rsp0_zero, rsp0_err;
    logic        rsp1_valid, rsp1_ready, rsp1_zero, rsp1_err;
    logic [31:0] rsp0_result, rsp1_result;
    logic [31:0] ula_in1, ula_in2, ula_result;
    logic [3:0]  ula_control;
    logic        zero_flag;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          n;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        int          rspDelay;
        logic [31:0] expResult;
        logic        expZero;
        logic        expErr;
    } vector_t;

    typedef struct {
        int          owner;
        logic [31:0] result;
        logic        zero;
        logic        err;
        logic [3:0]  ctrl;
        logic [31:0] in1;
        logic [31:0] in2;
        int          lat;
    } sbEntry_t;

    sbEntry_t sbQ[$];

    always #5 clk = ~clk;

    ula_arbiter #(.MUL_CYCLES(MUL)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp0_result(rsp0_result), .rsp0_zero(rsp0_zero), .rsp0_err(rsp0_err),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp1_result(rsp1_result), .rsp1_zero(rsp1_zero), .rsp1_err(rsp1_err),
        .ula_in1(ula_in1), .ula_in2(ula_in2), .ula_control(ula_control),
        .ula_result(ula_result), .zero_flag(zero_flag)
    );

    // Behavioural stand-in for the shared ULA.
    always_comb begin
        case (ula_control)
            4'b0000: ula_result = ula_in1 & ula_in2;
            4'b0001: ula_result = ula_in1 | ula_in2;
            4'b0010: ula_result = ula_in1 + ula_in2;
            4'b0011: ula_result = ula_in1 ^ ula_in2;
            4'b0100: ula_result = ula_in1 - ula_in2;
            4'b0101: ula_result = ($signed(ula_in1) < $signed(ula_in2)) ? 32'd1 : 32'd0;
            4'b0110: ula_result = ula_in1 * ula_in2;
            4'b0111: ula_result = ~(ula_in1 | ula_in2);
            4'b1000: ula_result = ula_in1 << ula_in2[4:0];
            default: ula_result = 32'd0;
        endcase
    end
    assign zero_flag = (ula_result == 32'd0);

    // Hard stop in case a sequence wedges somewhere unbounded.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkVal(input string name, input logic [31:0] act,
                            input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic driveReq(input int n, input logic v, input logic [31:0] a,
                            input logic [31:0] b, input logic [3:0] op);
        if (n == 0) begin
            req0_valid = v; req0_a = a; req0_b = b; req0_op = op;
        end else begin
            req1_valid = v; req1_a = a; req1_b = b; req1_op = op;
        end
    endtask

    task automatic doReset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        sbQ.delete();
    endtask

    // Present a request, wait (bounded) for its ready, push the expected
    // response on acceptance, then drop valid in the first EXEC cycle.
    task automatic applyStimulus(input int n, input logic [31:0] a,
                                 input logic [31:0] b, input logic [3:0] op,
                                 input logic [31:0] expResult, input logic expZero,
                                 input logic expErr, output int waited);
        sbEntry_t e;
        logic     rdy;
        driveReq(n, 1'b1, a, b, op);
        #1;
        waited = 0;
        rdy = (n == 0) ? req0_ready : req1_ready;
        while (!rdy && waited < 20) begin
            @(negedge clk);
            waited++;
            rdy = (n == 0) ? req0_ready : req1_ready;
        end
        if (!rdy) begin
            checkVal("acceptTimeout", 32'd0, 32'd1);
            driveReq(n, 1'b0, 32'd0, 32'd0, 4'd0);
            return;
        end
        e.owner  = n;
        e.result = expResult;
        e.zero   = expZero;
        e.err    = expErr;
        e.ctrl   = expErr ? 4'd0 : op;
        e.in1    = expErr ? 32'd0 : a;
        e.in2    = expErr ? 32'd0 : b;
        e.lat    = (op == 4'b0110) ? MUL : 1;
        sbQ.push_back(e);
        @(posedge clk);
        @(negedge clk);
        driveReq(n, 1'b0, 32'd0, 32'd0, 4'd0);
    endtask

    task automatic checkResp(input string tag, input sbEntry_t e);
        checkVal({tag, "_ownerValid"}, (e.owner == 0) ? rsp0_valid : rsp1_valid, 1);
        checkVal({tag, "_otherValid"}, (e.owner == 0) ? rsp1_valid : rsp0_valid, 0);
        checkVal({tag, "_result"}, (e.owner == 0) ? rsp0_result : rsp1_result, e.result);
        checkVal({tag, "_zero"}, (e.owner == 0) ? rsp0_zero : rsp1_zero, e.zero);
        checkVal({tag, "_err"}, (e.owner == 0) ? rsp0_err : rsp1_err, e.err);
        checkVal({tag, "_ulaCtrl"}, ula_control, 0);
        checkVal({tag, "_readies"}, {req1_ready, req0_ready}, 0);
    endtask

    // Follow the in-flight op through EXEC, then pop and compare the
    // response, hold it for rspDelay cycles, consume it and check it clears.
    task automatic checkOutput(input int rspDelay);
        sbEntry_t e;
        int       lat;
        if (sbQ.size() == 0) begin
            checkVal("scoreboardEmpty", 32'd0, 32'd1);
            return;
        end
        e = sbQ[0];
        lat = 0;
        while (!(rsp0_valid || rsp1_valid) && lat < 40) begin
            checkVal("execCtrl", ula_control, e.ctrl);
            checkVal("execIn1", ula_in1, e.in1);
            checkVal("execIn2", ula_in2, e.in2);
            checkVal("execReadies", {req1_ready, req0_ready}, 0);
            @(negedge clk);
            lat++;
        end
        checkVal("latency", lat, e.lat);
        e = sbQ.pop_front();
        if (!(rsp0_valid || rsp1_valid)) return;
        checkResp("resp", e);
        for (int d = 0; d < rspDelay; d++) begin
            @(negedge clk);
            checkResp("stall", e);
        end
        if (e.owner == 0) rsp0_ready = 1'b1;
        else              rsp1_ready = 1'b1;
        @(negedge clk);
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        checkVal("afterConsumeValid", {rsp1_valid, rsp0_valid}, 0);
        checkVal("afterConsumeResult", rsp0_result | rsp1_result, 0);
        checkVal("afterConsumeFlags", {rsp1_zero, rsp1_err, rsp0_zero, rsp0_err}, 0);
    endtask

    initial begin
        vector_t vecs[12];
        int      waited;

        //          n  a             b             op       dly result        z     e
        vecs[0]  = '{0, 32'd5,        32'd7,        4'b0010, 0, 32'd12,       1'b0, 1'b0};
        vecs[1]  = '{1, 32'd6,        32'd7,        4'b0110, 0, 32'd42,       1'b0, 1'b0};
        vecs[2]  = '{0, 32'd5,        32'd3,        4'b1111, 0, 32'd0,        1'b0, 1'b1};
        vecs[3]  = '{1, 32'hFFFF0000, 32'h0F0F0F0F, 4'b0000, 1, 32'h0F0F0000, 1'b0, 1'b0};
        vecs[4]  = '{0, 32'd3,        32'd3,        4'b0100, 0, 32'd0,        1'b1, 1'b0};
        vecs[5]  = '{1, 32'd0,        32'd0,        4'b0110, 0, 32'd0,        1'b1, 1'b0};
        vecs[6]  = '{0, 32'd1,        32'd4,        4'b1000, 0, 32'd16,       1'b0, 1'b0};
        vecs[7]  = '{1, 32'd2,        32'd5,        4'b0101, 0, 32'd1,        1'b0, 1'b0};
        vecs[8]  = '{0, 32'd1,        32'd1,        4'b1001, 0, 32'd0,        1'b0, 1'b1};
        vecs[9]  = '{1, 32'hF0,       32'h0F,       4'b0011, 2, 32'hFF,       1'b0, 1'b0};
        vecs[10] = '{0, 32'hFFFFFFFF, 32'd1,        4'b0010, 0, 32'd0,        1'b1, 1'b0};
        vecs[11] = '{1, 32'd0,        32'd0,        4'b0111, 0, 32'hFFFFFFFF, 1'b0, 1'b0};

        driveReq(0, 1'b0, 32'd0, 32'd0, 4'd0);
        driveReq(1, 1'b0, 32'd0, 32'd0, 4'd0);
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        doReset();

        $display("[TB] reset state");
        checkVal("rstValid", {rsp1_valid, rsp0_valid}, 0);
        checkVal("rstReady", {req1_ready, req0_ready}, 0);
        checkVal("rstUla", ula_in1 | ula_in2 | {28'd0, ula_control}, 0);
        checkVal("rstRsp", rsp0_result | rsp1_result, 0);

        $display("[TB] vector table");
        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].n, vecs[i].a, vecs[i].b, vecs[i].op,
                          vecs[i].expResult, vecs[i].expZero, vecs[i].expErr, waited);
            checkOutput(vecs[i].rspDelay);
        end

        $display("[TB] simultaneous requests after reset");
        doReset();
        driveReq(1, 1'b1, 32'd1, 32'd2, 4'b0001);
        applyStimulus(0, 32'd9, 32'd9, 4'b0100, 32'd0, 1'b1, 1'b0, waited);
        checkVal("bothFirstWait", waited, 0);
        checkOutput(0);
        applyStimulus(1, 32'd1, 32'd2, 4'b0001, 32'd3, 1'b0, 1'b0, waited);
        checkVal("bothSecondWait", waited, 0);
        checkOutput(0);
        driveReq(0, 1'b1, 32'd0, 32'd0, 4'd0);
        driveReq(1, 1'b1, 32'd0, 32'd0, 4'd0);
        #1;
        checkVal("rrBackToZero", {req1_ready, req0_ready}, 2'b01);
        driveReq(0, 1'b0, 32'd0, 32'd0, 4'd0);
        driveReq(1, 1'b0, 32'd0, 32'd0, 4'd0);

        $display("[TB] stalled response with competing request");
        driveReq(1, 1'b1, 32'd10, 32'd20, 4'b0010);
        applyStimulus(0, 32'd8, 32'd1, 4'b0010, 32'd9, 1'b0, 1'b0, waited);
        checkOutput(5);
        checkVal("stallReq1ReadyAfter", req1_ready, 1);
        applyStimulus(1, 32'd10, 32'd20, 4'b0010, 32'd30, 1'b0, 1'b0, waited);
        checkVal("stallReq1Wait", waited, 0);
        checkOutput(0);

        $display("[TB] reset during multiply");
        applyStimulus(0, 32'd4, 32'd4, 4'b0010, 32'd8, 1'b0, 1'b0, waited);
        checkOutput(0);
        applyStimulus(1, 32'd6, 32'd7, 4'b0110, 32'd42, 1'b0, 1'b0, waited);
        checkVal("mulExecCtrl", ula_control, 4'b0110);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        sbQ.delete();
        checkVal("abortUla", {28'd0, ula_control} | ula_in1, 0);
        for (int k = 0; k < 6; k++) begin
            checkVal("abortNoRsp", {rsp1_valid, rsp0_valid}, 0);
            @(negedge clk);
        end
        driveReq(0, 1'b1, 32'd0, 32'd0, 4'd0);
        driveReq(1, 1'b1, 32'd0, 32'd0, 4'd0);
        #1;
        checkVal("abortRrZero", {req1_ready, req0_ready}, 2'b01);
        driveReq(0, 1'b0, 32'd0, 32'd0, 4'd0);
        driveReq(1, 1'b0, 32'd0, 32'd0, 4'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
